pcf8563_i2c_responder: RTL and testbench
========================================

PCF8563_I2C_RESPONDER -- requirements
Module: pcf8563_i2c_responder

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h51, the 7-bit slave address (write byte 8'hA2, read byte 8'hA3).
REQ-003 SHALL have port clk  input  1  system clock, at least 16x the SCL rate.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port i2c_sclk  input  1  I2C clock driven by the master.
REQ-006 SHALL have port i2c_sdat  inout  1  open-drain data line: driven 1'b0 or released to 1'bz, never driven 1.
REQ-007 SHALL have port time_out  output  24  {hours, minutes, seconds} mirror of registers 0x04/0x03/0x02.
REQ-008 SHALL have port date_out  output  32  {years, months, days, weekdays} mirror of registers 0x08/0x07/0x05/0x06.
REQ-009 SHALL have port wr_strobe  output  1  one-clk pulse per accepted data-byte write.
REQ-010 SHALL have port wr_addr  output  4  register index of that write, valid with wr_strobe.
REQ-011 SHALL have port wr_data  output  8  data byte of that write, valid with wr_strobe.

Function
REQ-012 SHALL synchronise SCL and SDA through 2 flops each and detect edges on the synchronised values.
REQ-013 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both apply in every state.
REQ-014 SHALL sample SDA on each SCL rising edge and change its SDA drive only after an SCL falling edge.
REQ-015 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 SHALL go to ADDR on any START, including a repeated START, and to IDLE on STOP; both release SDA.
REQ-017 SHALL shift 8 address bits in ADDR, MSB first; bit 0 is R/W.
REQ-018 SHALL ACK on a match of bits [7:1] == DEV_ADDR by pulling SDA low for the 9th SCL period; on a mismatch it SHALL return to IDLE with SDA released.
REQ-019 SHALL, after an ACKed write address, take the next byte as the register pointer (low 4 bits kept, upper bits ignored), ACK it, then move to WDATA.
REQ-020 SHALL, for each byte received in WDATA, write it to reg[ptr], pulse wr_strobe one clk after the 8th SCL rising edge, ACK it, and increment ptr.
REQ-021 SHALL, after an ACKed read address, shift out reg[ptr] MSB first in RDATA, starting with the SCL falling edge that ends the ACK.
REQ-022 SHALL release SDA in RDATA_ACK and sample the master's bit: ACK (0) increments ptr and sends the next byte; NACK (1) goes to IDLE.
REQ-023 SHALL wrap the pointer from 0xF to 0x0.
REQ-024 SHALL keep the pointer across STOP/START, so a pointer-only write followed by a repeated-START read works.
REQ-025 SHALL hold a register file of 16x8 bits; time_out/date_out SHALL be combinational mirrors of it.
REQ-026 SHALL ignore a START/STOP that occurs mid-byte: the partial byte is discarded and nothing is written.

Reset
REQ-027 SHALL, on rst, clear state to IDLE, all registers to 0x00, ptr to 0, wr_strobe to 0, and bit counter to 0, and release SDA.
REQ-028 SHALL make a reset mid-transaction release SDA within one clk and ignore the bus until the next START.

Structure
REQ-029 SHALL place in the shared package: the register-index constants (0x00-0x0F, same names as the controller side), the state encoding, and DEV_ADDR default.
REQ-030 SHALL use one sub-module i2c_bus_sync (sync flops, SCL rise/fall, START/STOP detect); the FSM and register file stay in the top module.

Verification
REQ-031 SHALL cover: write A2, 02, 45, STOP -> ACK on all three bytes, wr_strobe once with addr 2 / data 0x45, time_out[7:0] = 0x45.
REQ-032 SHALL cover: write A2, 0F, 11, 22 -> reg 0xF = 0x11, reg 0x0 = 0x22 (pointer wrap).
REQ-033 SHALL cover: write A2, 03, repeated START, A3, read 2 bytes (ACK then NACK) -> returns reg 0x03 then reg 0x04, SDA released after NACK.
REQ-034 SHALL cover: address 0xA4 -> SDA never pulled low, no wr_strobe, registers unchanged.
REQ-035 SHALL cover: rst asserted during a read data bit driving 0 -> SDA goes to z, all outputs return to 0.
REQ-036 SHALL cover: STOP after 4 bits of a data byte -> no write, state IDLE.

Source files
------------

// File: rtl/pcf8563_i2c_responder_pkg.sv
// Shared definitions for the PCF8563-compatible I2C responder.
// Contents:
//   - DEV_ADDR_DEFAULT : 7-bit slave address (write byte 0xA2, read byte 0xA3)
//   - REG_*            : register indices 0x00-0x0F of the RTC register map
//   - state_t          : protocol FSM state encoding
package pcf8563_i2c_responder_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h51;

    localparam logic [3:0] REG_CONTROL_1     = 4'h0;
    localparam logic [3:0] REG_CONTROL_2     = 4'h1;
    localparam logic [3:0] REG_SECONDS       = 4'h2;
    localparam logic [3:0] REG_MINUTES       = 4'h3;
    localparam logic [3:0] REG_HOURS         = 4'h4;
    localparam logic [3:0] REG_DAYS          = 4'h5;
    localparam logic [3:0] REG_WEEKDAYS      = 4'h6;
    localparam logic [3:0] REG_MONTHS        = 4'h7;
    localparam logic [3:0] REG_YEARS         = 4'h8;
    localparam logic [3:0] REG_MINUTE_ALARM  = 4'h9;
    localparam logic [3:0] REG_HOUR_ALARM    = 4'hA;
    localparam logic [3:0] REG_DAY_ALARM     = 4'hB;
    localparam logic [3:0] REG_WEEKDAY_ALARM = 4'hC;
    localparam logic [3:0] REG_CLKOUT_CTRL   = 4'hD;
    localparam logic [3:0] REG_TIMER_CTRL    = 4'hE;
    localparam logic [3:0] REG_TIMER         = 4'hF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

endpackage

// File: rtl/pcf8563_i2c_responder_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and derives bus events.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   scl_in, sda_in    : raw bus lines
//   sda               : synchronised SDA level
//   scl_rise/scl_fall : one-clk pulses on synchronised SCL edges
//   start_det         : SDA falling while SCL high
//   stop_det          : SDA rising while SCL high
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0],[1] are the two synchroniser flops, [2] holds the previous
    // synchronised value for edge detection. Reset to 1 (idle bus) so
    // leaving reset never looks like an edge.
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_in};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    assign sda       = sda_pipe_q[1];
    assign scl_rise  =  scl_pipe_q[1] & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_pipe_q[1] &  scl_pipe_q[2];
    assign start_det =  scl_pipe_q[1] &  scl_pipe_q[2] & ~sda_pipe_q[1] &  sda_pipe_q[2];
    assign stop_det  =  scl_pipe_q[1] &  scl_pipe_q[2] &  sda_pipe_q[1] & ~sda_pipe_q[2];

endmodule

// File: rtl/pcf8563_i2c_responder.sv
// pcf8563_i2c_responder: I2C slave exposing a 16x8 PCF8563-style register file.
// Ports:
//   clk, rst   : system clock (>= 16x SCL), asynchronous active-high reset
//   i2c_sclk   : bus clock from the master
//   i2c_sdat   : open-drain data line, only ever driven 0 or released
//   time_out   : {hours, minutes, seconds}
//   date_out   : {years, months, days, weekdays}
//   wr_strobe  : one-clk pulse per data byte written; wr_addr/wr_data qualify it
//   dbg_state  : current protocol FSM state
module pcf8563_i2c_responder
    import pcf8563_i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic [23:0] time_out,
    output logic [31:0] date_out,
    output logic        wr_strobe,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output state_t      dbg_state
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (i2c_sclk),
        .sda_in    (i2c_sdat),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        sda_low_q, sda_low_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];
    logic [7:0]  shift_in;

    assign shift_in = {shift_q[6:0], sda};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_low_d   = sda_low_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (stop_det) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Data byte commits on its 8th rising edge, so a
                        // START/STOP earlier in the byte never writes.
                        if (state_q == WDATA && bit_cnt_q == 4'd7) begin
                            regs_d[ptr_q] = shift_in;
                            wr_strobe_d   = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = shift_in;
                            ptr_d         = ptr_q + 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_low_d = 1'b1;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d   = IDLE;
                                sda_low_d = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = shift_q[3:0];
                            state_d = PTR_ACK;
                        end else begin
                            state_d = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d   = RDATA;
                            shift_d   = regs_q[ptr_q];
                            sda_low_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d   = PTR;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = WDATA;
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RDATA_ACK;
                            sda_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            // Present the next bit; shift_q[7] was just sampled.
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda) state_d = IDLE;
                        else     ptr_d   = ptr_q + 4'd1;
                    end else if (scl_fall) begin
                        state_d   = RDATA;
                        shift_d   = regs_q[ptr_q];
                        sda_low_d = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 4'd0;
            rw_q        <= 1'b0;
            sda_low_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_low_q   <= sda_low_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign i2c_sdat  = sda_low_q ? 1'b0 : 1'bz;
    assign time_out  = {regs_q[REG_HOURS], regs_q[REG_MINUTES], regs_q[REG_SECONDS]};
    assign date_out  = {regs_q[REG_YEARS], regs_q[REG_MONTHS], regs_q[REG_DAYS], regs_q[REG_WEEKDAYS]};
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pcf8563_i2c_responder.sv
module tb_pcf8563_i2c_responder;
  import pcf8563_i2c_responder_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // bus: master drives SCL push-pull, SDA open-drain
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  logic [23:0] time_out;
  logic [31:0] date_out;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  state_t      dbg_state;

  pcf8563_i2c_responder dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda_bus),
    .time_out  (time_out),
    .date_out  (date_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic dut_low_seen = 1'b0;
  logic [11:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write-strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!m_sda_low && sda_bus === 1'b0) dut_low_seen = 1'b1;
    if (!rst && wr_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_wr_q.size() == 0) check("wr_unexpected_qsize", exp_wr_q.size(), 1);
      else check("wr_event", {20'h0, wr_addr, wr_data}, {20'h0, exp_wr_q.pop_front()});
    end
  end

  // driver tasks
  task automatic phase();
    repeat (8) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; scl = 1'b1; phase();
    m_sda_low = 1'b1; phase();
    scl = 1'b0; phase();
  endtask

  task automatic i2c_rep_start();
    m_sda_low = 1'b0; phase();
    scl = 1'b1; phase();
    m_sda_low = 1'b1; phase();
    scl = 1'b0; phase();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; phase();
    scl = 1'b1; phase();
    m_sda_low = 1'b0; phase();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      m_sda_low = ~b[i]; phase();
      scl = 1'b1; phase();
      scl = 1'b0;
    end
    phase();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda_low = 1'b0; phase();
    scl = 1'b1; repeat (4) @(posedge clk);
    ack = sda_bus;
    repeat (4) @(posedge clk);
    scl = 1'b0; phase();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] data);
    m_sda_low = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      phase();
      scl = 1'b1; repeat (4) @(posedge clk);
      data = {data[6:0], sda_bus};
      repeat (4) @(posedge clk);
      scl = 1'b0;
    end
    m_sda_low = ~nack; phase();
    scl = 1'b1; phase();
    scl = 1'b0; phase();
    m_sda_low = 1'b0;
  endtask

  initial begin
    logic        ack;
    logic [7:0]  rd;
    logic [23:0] saved_time;
    logic [31:0] saved_date;
    int          saved_strobes;

    // reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_time", time_out, 0);
    check("rst_date", date_out, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_sda", sda_bus, 1);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // single write: seconds = 0x45
    i2c_start();
    write_byte(8'hA2, ack); check("t1_ack_addr", ack, 0);
    write_byte(8'h02, ack); check("t1_ack_ptr", ack, 0);
    exp_wr_q.push_back({4'h2, 8'h45});
    write_byte(8'h45, ack); check("t1_ack_data", ack, 0);
    i2c_stop();
    check("t1_seconds", time_out[7:0], 8'h45);
    check("t1_strobes", strobe_cnt, 1);
    check("t1_state", dbg_state, IDLE);

    // pointer wrap 0xF -> 0x0
    i2c_start();
    write_byte(8'hA2, ack); check("t2_ack_addr", ack, 0);
    write_byte(8'h0F, ack); check("t2_ack_ptr", ack, 0);
    exp_wr_q.push_back({4'hF, 8'h11});
    write_byte(8'h11, ack); check("t2_ack_d0", ack, 0);
    exp_wr_q.push_back({4'h0, 8'h22});
    write_byte(8'h22, ack); check("t2_ack_d1", ack, 0);
    i2c_stop();
    check("t2_strobes", strobe_cnt, 3);
    // read back across the wrap
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h0F, ack);
    i2c_rep_start();
    write_byte(8'hA3, ack); check("t2_ack_rd_addr", ack, 0);
    exp_rd_q.push_back(8'h11);
    read_byte(1'b0, rd); check("t2_rd_regF", rd, exp_rd_q.pop_front());
    exp_rd_q.push_back(8'h22);
    read_byte(1'b1, rd); check("t2_rd_reg0", rd, exp_rd_q.pop_front());
    i2c_stop();

    // minutes/hours then pointer write + repeated-START read
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h03, ack);
    exp_wr_q.push_back({4'h3, 8'h59});
    write_byte(8'h59, ack);
    exp_wr_q.push_back({4'h4, 8'h23});
    write_byte(8'h23, ack);
    i2c_stop();
    check("t3_time", time_out, 24'h235945);
    i2c_start();
    write_byte(8'hA2, ack); check("t3_ack_addr", ack, 0);
    write_byte(8'h03, ack); check("t3_ack_ptr", ack, 0);
    i2c_rep_start();
    write_byte(8'hA3, ack); check("t3_ack_rd_addr", ack, 0);
    exp_rd_q.push_back(8'h59);
    read_byte(1'b0, rd); check("t3_rd_reg3", rd, exp_rd_q.pop_front());
    exp_rd_q.push_back(8'h23);
    read_byte(1'b1, rd); check("t3_rd_reg4", rd, exp_rd_q.pop_front());
    check("t3_sda_released", sda_bus, 1);
    check("t3_state", dbg_state, IDLE);
    i2c_stop();

    // wrong address 0xA4
    saved_time = time_out;
    saved_date = date_out;
    saved_strobes = strobe_cnt;
    dut_low_seen = 1'b0;
    i2c_start();
    write_byte(8'hA4, ack); check("t4_nack_addr", ack, 1);
    write_byte(8'h02, ack); check("t4_nack_b1", ack, 1);
    write_byte(8'h77, ack); check("t4_nack_b2", ack, 1);
    i2c_stop();
    check("t4_never_low", dut_low_seen, 0);
    check("t4_strobes", strobe_cnt, saved_strobes);
    check("t4_time", time_out, saved_time);
    check("t4_date", date_out, saved_date);

    // STOP after 4 data bits
    i2c_start();
    write_byte(8'hA2, ack); check("t5_ack_addr", ack, 0);
    write_byte(8'h05, ack); check("t5_ack_ptr", ack, 0);
    send_bits(8'hA0, 4);
    i2c_stop();
    check("t5_strobes", strobe_cnt, saved_strobes);
    check("t5_state", dbg_state, IDLE);
    check("t5_days", date_out[15:8], 8'h00);

    // reset while DUT drives a 0 data bit (reg 2 = 0x45, MSB 0)
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h02, ack);
    i2c_rep_start();
    write_byte(8'hA3, ack); check("t6_ack_rd_addr", ack, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_dut_drives_0", sda_bus, 0);
    rst = 1'b1;
    #2;
    check("t6_sda_released", sda_bus, 1);
    check("t6_time", time_out, 0);
    check("t6_date", date_out, 0);
    check("t6_strobe", wr_strobe, 0);
    check("t6_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    rst = 1'b0;
    // bus activity without START is ignored
    send_bits(8'hA2, 8);
    check("t6_ignored_state", dbg_state, IDLE);
    i2c_stop();
    i2c_start();
    write_byte(8'hA2, ack); check("t6_ack_after_rst", ack, 0);
    write_byte(8'h06, ack);
    exp_wr_q.push_back({4'h6, 8'h03});
    write_byte(8'h03, ack);
    i2c_stop();
    check("t6_weekday", date_out[7:0], 8'h03);

    check("end_wr_q_empty", exp_wr_q.size(), 0);
    check("end_rd_q_empty", exp_rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
